// File: rtl/gpu_text_pkg.sv
// Constants and state encoding shared by the text console writer and the
// text sequencer: grid geometry, fill code and console control codes.
package gpu_text_pkg;

    localparam int unsigned COLS   = 40;
    localparam int unsigned ROWS   = 30;
    localparam int unsigned ADDR_W = 12;

    localparam logic [7:0] BLANK = 8'h20;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_BS = 8'h08;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        CLEAR,
        SC_RD,
        SC_WR,
        SC_BLANK
    } state_e;

endpackage

// File: rtl/text_console_writer_if.sv
// Byte-stream handshake, display RAM port A and cursor/status signals of the
// console writer; slave is the writer side, master is the host/RAM side.
interface text_console_writer_if;
    import gpu_text_pkg::*;

    logic [7:0]        char_in;
    logic              char_valid;
    logic              char_ready;
    logic              cls;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_en;
    logic              mem_we;
    logic [7:0]        mem_rdata;
    logic [5:0]        cursor_x;
    logic [4:0]        cursor_y;
    logic              busy;

    modport slave (
        input  char_in, char_valid, cls, mem_rdata,
        output char_ready, mem_addr, mem_wdata, mem_en, mem_we,
               cursor_x, cursor_y, busy
    );

    modport master (
        output char_in, char_valid, cls, mem_rdata,
        input  char_ready, mem_addr, mem_wdata, mem_en, mem_we,
               cursor_x, cursor_y, busy
    );

endinterface

// File: rtl/text_addr_calc.sv
// Cell address of a text grid position: y*40 + x computed as (y<<5)+(y<<3)+x.
module text_addr_calc
    import gpu_text_pkg::*;
(
    input  logic [5:0]        x,
    input  logic [4:0]        y,
    output logic [ADDR_W-1:0] addr
);

    assign addr = (ADDR_W'(y) << 5) + (ADDR_W'(y) << 3) + ADDR_W'(x);

endmodule

// File: rtl/text_console_writer.sv
// Console front end: accepts bytes, tracks the cursor, writes characters into
// display RAM port A and performs clear-screen and one-line scroll-up.
module text_console_writer
    import gpu_text_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    text_console_writer_if.slave bus
);

    localparam logic [5:0]        X_LAST      = 6'(COLS - 1);
    localparam logic [4:0]        Y_LAST      = 5'(ROWS - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST   = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] SRC_FIRST   = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] DST_LAST    = ADDR_W'(COLS * (ROWS - 1) - 1);
    localparam logic [ADDR_W-1:0] BLANK_FIRST = ADDR_W'(COLS * (ROWS - 1));
    localparam logic [ADDR_W-1:0] STEP_BACK   = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] STEP_FWD    = ADDR_W'(COLS + 1);

    state_e            state_q, state_d;
    logic [5:0]        x_q, x_d;
    logic [4:0]        y_q, y_d;
    logic              cls_pend_q, cls_pend_d;
    logic              scroll_pend_q, scroll_pend_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;

    logic [5:0]        calc_x;
    logic [ADDR_W-1:0] cell_addr;
    logic              is_print;

    // Backspace targets the cell left of the cursor; everything else the cursor cell.
    assign calc_x   = (bus.char_in == CH_BS) ? x_q - 6'd1 : x_q;
    assign is_print = (bus.char_in >= 8'h20) && (bus.char_in <= 8'h7E);

    text_addr_calc u_addr (
        .x    (calc_x),
        .y    (y_q),
        .addr (cell_addr)
    );

    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        cls_pend_d    = cls_pend_q | bus.cls;
        scroll_pend_d = scroll_pend_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_en_d      = 1'b0;
        mem_we_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (cls_pend_q) begin
                    state_d     = CLEAR;
                    cls_pend_d  = 1'b0;
                    x_d         = '0;
                    y_d         = '0;
                    mem_addr_d  = '0;
                    mem_wdata_d = BLANK;
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b1;
                end else if (bus.char_valid) begin
                    if (is_print) begin
                        state_d     = WRITE;
                        mem_addr_d  = cell_addr;
                        mem_wdata_d = bus.char_in;
                        mem_en_d    = 1'b1;
                        mem_we_d    = 1'b1;
                        if (x_q == X_LAST) begin
                            x_d = '0;
                            if (y_q < Y_LAST) y_d = y_q + 5'd1;
                            else              scroll_pend_d = 1'b1;
                        end else begin
                            x_d = x_q + 6'd1;
                        end
                    end else if (bus.char_in == CH_CR) begin
                        x_d = '0;
                    end else if (bus.char_in == CH_LF) begin
                        x_d = '0;
                        if (y_q < Y_LAST) begin
                            y_d = y_q + 5'd1;
                        end else begin
                            state_d    = SC_RD;
                            mem_addr_d = SRC_FIRST;
                            mem_en_d   = 1'b1;
                        end
                    end else if ((bus.char_in == CH_BS) && (x_q != '0)) begin
                        state_d     = WRITE;
                        x_d         = x_q - 6'd1;
                        mem_addr_d  = cell_addr;
                        mem_wdata_d = BLANK;
                        mem_en_d    = 1'b1;
                        mem_we_d    = 1'b1;
                    end
                end
            end
            WRITE: begin
                // A wrap on the last row defers the scroll until the character is written.
                if (scroll_pend_q) begin
                    state_d       = SC_RD;
                    scroll_pend_d = 1'b0;
                    mem_addr_d    = SRC_FIRST;
                    mem_en_d      = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            CLEAR: begin
                cls_pend_d = 1'b0;
                if (mem_addr_q == ADDR_LAST) begin
                    state_d = IDLE;
                end else begin
                    mem_addr_d = mem_addr_q + 1'b1;
                    mem_en_d   = 1'b1;
                    mem_we_d   = 1'b1;
                end
            end
            SC_RD: begin
                state_d    = SC_WR;
                mem_addr_d = mem_addr_q - STEP_BACK;
                mem_en_d   = 1'b1;
                mem_we_d   = 1'b1;
            end
            SC_WR: begin
                if (mem_addr_q == DST_LAST) begin
                    state_d     = SC_BLANK;
                    mem_addr_d  = BLANK_FIRST;
                    mem_wdata_d = BLANK;
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b1;
                end else begin
                    state_d    = SC_RD;
                    mem_addr_d = mem_addr_q + STEP_FWD;
                    mem_en_d   = 1'b1;
                end
            end
            SC_BLANK: begin
                if (mem_addr_q == ADDR_LAST) begin
                    state_d = IDLE;
                end else begin
                    mem_addr_d = mem_addr_q + 1'b1;
                    mem_en_d   = 1'b1;
                    mem_we_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            x_q           <= '0;
            y_q           <= '0;
            cls_pend_q    <= 1'b1;
            scroll_pend_q <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            cls_pend_q    <= cls_pend_d;
            scroll_pend_q <= scroll_pend_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_en_q      <= mem_en_d;
            mem_we_q      <= mem_we_d;
        end
    end

    // Read data arrives during SC_WR, too late to register; forward it directly.
    assign bus.mem_wdata  = (state_q == SC_WR) ? bus.mem_rdata : mem_wdata_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_en     = mem_en_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.cursor_x   = x_q;
    assign bus.cursor_y   = y_q;
    assign bus.char_ready = (state_q == IDLE) && !cls_pend_q;
    assign bus.busy       = (state_q inside {CLEAR, SC_RD, SC_WR, SC_BLANK}) ||
                            ((state_q == IDLE) && cls_pend_q);

endmodule

// File: tb/tb_text_console_writer.sv
// Directed/random bench for text_console_writer against a screen-array model.
module tb_text_console_writer;
    import gpu_text_pkg::*;

    localparam int CELLS = COLS * ROWS;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic preload_req = 1'b0;
    always #5 clk = ~clk;

    text_console_writer_if tif();

    text_console_writer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (tif)
    );

    logic [7:0] ram [0:CELLS-1];

    always @(posedge clk) begin
        if (preload_req) begin
            for (int i = 0; i < CELLS; i++) ram[i] <= 8'(i);
        end else if (tif.mem_en && (int'(tif.mem_addr) < CELLS)) begin
            if (tif.mem_we) ram[tif.mem_addr] <= tif.mem_wdata;
            else            tif.mem_rdata     <= ram[tif.mem_addr];
        end
    end

    int unsigned n_asserts = 0;
    int unsigned n_fail    = 0;
    int wa[$], wd[$], wc[$];
    int cyc = 0;
    int busy_cnt = 0;
    int ref_scr [0:CELLS-1];
    int ref_x = 0, ref_y = 0;

    `define CHK(tag, obs, exp) begin \
        n_asserts++; \
        assert ((obs) === (exp)) else begin \
            n_fail++; \
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp); \
        end \
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (tif.mem_en && tif.mem_we) begin
            wa.push_back(int'(tif.mem_addr));
            wd.push_back(int'(tif.mem_wdata));
            wc.push_back(cyc);
        end
        if (tif.busy) busy_cnt++;
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        wc.delete();
    endtask

    function automatic void model_newline();
        if (ref_y < ROWS - 1) begin
            ref_y++;
        end else begin
            for (int i = 0; i < CELLS - COLS; i++) ref_scr[i] = ref_scr[i + COLS];
            for (int i = CELLS - COLS; i < CELLS; i++) ref_scr[i] = int'(BLANK);
        end
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < CELLS; i++) ref_scr[i] = int'(BLANK);
        ref_x = 0;
        ref_y = 0;
    endfunction

    function automatic void model_char(input logic [7:0] c);
        if (c >= 8'h20 && c <= 8'h7E) begin
            ref_scr[ref_y * COLS + ref_x] = int'(c);
            ref_x++;
            if (ref_x == COLS) begin
                ref_x = 0;
                model_newline();
            end
        end else if (c == CH_CR) begin
            ref_x = 0;
        end else if (c == CH_LF) begin
            ref_x = 0;
            model_newline();
        end else if (c == CH_BS && ref_x > 0) begin
            ref_x--;
            ref_scr[ref_y * COLS + ref_x] = int'(BLANK);
        end
    endfunction

    task automatic send(input logic [7:0] c);
        int n = 0;
        while (!tif.char_ready && n < 20000) begin
            tick();
            n++;
        end
        `CHK("send_ready", tif.char_ready, 1'b1)
        tif.char_in    = c;
        tif.char_valid = 1'b1;
        tick();
        tif.char_valid = 1'b0;
        model_char(c);
    endtask

    task automatic drain();
        int n = 0;
        while ((!tif.char_ready || tif.busy) && n < 20000) begin
            tick();
            n++;
        end
        `CHK("drain_idle", tif.char_ready, 1'b1)
    endtask

    task automatic check_screen(input string tag);
        int bad = 0;
        for (int i = 0; i < CELLS; i++)
            if (ram[i] !== 8'(ref_scr[i])) bad++;
        `CHK(tag, bad, 0)
    endtask

    task automatic check_cursor(input string tag);
        `CHK(tag, int'(tif.cursor_x), ref_x)
        `CHK(tag, int'(tif.cursor_y), ref_y)
    endtask

    task automatic check_reset_values();
        `CHK("rst_mem_en", tif.mem_en, 1'b0)
        `CHK("rst_mem_we", tif.mem_we, 1'b0)
        `CHK("rst_mem_addr", tif.mem_addr, 12'd0)
        `CHK("rst_mem_wdata", tif.mem_wdata, 8'd0)
        `CHK("rst_cursor_x", tif.cursor_x, 6'd0)
        `CHK("rst_cursor_y", tif.cursor_y, 5'd0)
        `CHK("rst_char_ready", tif.char_ready, 1'b0)
        `CHK("rst_busy", tif.busy, 1'b1)
    endtask

    initial begin
        int n;
        int bad;
        int row1_char;
        logic [7:0] c;

        tif.char_in    = 8'h00;
        tif.char_valid = 1'b0;
        tif.cls        = 1'b0;

        repeat (3) tick();
        check_reset_values();

        // Reset release: full clear in consecutive cycles
        clear_log();
        reset = 1'b1;
        n = 0;
        while (!tif.char_ready && n < 2000) begin
            tick();
            n++;
        end
        `CHK("clear_ready_cycle", n, 1201)
        `CHK("clear_writes", wa.size(), CELLS)
        bad = 0;
        for (int i = 0; i < wa.size(); i++)
            if (wa[i] != i || wd[i] != int'(BLANK) || wc[i] != wc[0] + i) bad++;
        `CHK("clear_sequence", bad, 0)
        model_clear();
        check_screen("clear_screen");
        check_cursor("clear_cursor");

        // Single characters and throughput
        clear_log();
        send(8'h41);
        `CHK("a_writes", wa.size(), 1)
        `CHK("a_addr", wa[0], 0)
        `CHK("a_data", wd[0], 8'h41)
        `CHK("a_cursor_x", tif.cursor_x, 6'd1)
        `CHK("a_ready_low", tif.char_ready, 1'b0)
        tick();
        `CHK("a_ready_back", tif.char_ready, 1'b1)
        `CHK("a_idle_en", tif.mem_en, 1'b0)
        clear_log();
        send(8'h42);
        `CHK("b_addr", wa[0], 1)

        // Line feeds to row 3, then a full random row
        repeat (3) begin
            send(CH_LF);
            `CHK("lf_ready_stays", tif.char_ready, 1'b1)
        end
        check_cursor("lf_cursor");
        clear_log();
        repeat (COLS) send(8'($urandom_range(32, 126)));
        drain();
        `CHK("row_writes", wa.size(), COLS)
        `CHK("row_last_addr", wa[COLS-1], 159)
        `CHK("row_wrap_x", tif.cursor_x, 6'd0)
        `CHK("row_wrap_y", tif.cursor_y, 5'd4)
        check_screen("row_screen");

        // Backspace at column 0 and a discarded byte
        clear_log();
        send(CH_BS);
        repeat (2) tick();
        `CHK("bs0_writes", wa.size(), 0)
        check_cursor("bs0_cursor");
        send(8'($urandom_range(128, 255)));
        repeat (2) tick();
        `CHK("discard_writes", wa.size(), 0)
        check_cursor("discard_cursor");

        // cls pulse, second pulse during the clear is absorbed
        clear_log();
        tif.cls = 1'b1;
        tick();
        tif.cls = 1'b0;
        repeat (50) tick();
        tif.cls = 1'b1;
        tick();
        tif.cls = 1'b0;
        drain();
        model_clear();
        `CHK("cls_writes", wa.size(), CELLS)
        check_screen("cls_screen");
        check_cursor("cls_cursor");

        // Backspace at (5,2)
        send(CH_LF);
        send(CH_LF);
        repeat (5) send(8'($urandom_range(32, 126)));
        drain();
        clear_log();
        send(CH_BS);
        drain();
        `CHK("bs_writes", wa.size(), 1)
        `CHK("bs_addr", wa[0], 84)
        `CHK("bs_data", wd[0], int'(BLANK))
        `CHK("bs_cursor_x", tif.cursor_x, 6'd4)
        `CHK("bs_cursor_y", tif.cursor_y, 5'd2)
        check_screen("bs_screen");

        // Scroll by LF on the last row with a patterned screen
        preload_req = 1'b1;
        tick();
        preload_req = 1'b0;
        for (int i = 0; i < CELLS; i++) ref_scr[i] = i & 8'hFF;
        repeat (27) send(CH_LF);
        check_cursor("pre_scroll_cursor");
        clear_log();
        busy_cnt = 0;
        send(CH_LF);
        n = 0;
        while (tif.busy && n < 3000) begin
            tick();
            n++;
        end
        `CHK("scroll_busy_cycles", busy_cnt, 2360)
        `CHK("scroll_addr0", ram[0], 8'd40)
        `CHK("scroll_addr1159", ram[1159], 8'hAF)
        bad = 0;
        for (int i = CELLS - COLS; i < CELLS; i++) if (ram[i] !== BLANK) bad++;
        `CHK("scroll_blank_row", bad, 0)
        `CHK("scroll_idle_en", tif.mem_en, 1'b0)
        check_cursor("scroll_cursor");
        check_screen("scroll_screen");

        // Random row on the last line wraps into a scroll
        repeat (COLS) send(8'($urandom_range(32, 126)));
        drain();
        check_cursor("wrap_scroll_cursor");
        check_screen("wrap_scroll_screen");

        // cls during scroll with a byte held valid
        row1_char = ref_scr[COLS];
        clear_log();
        send(CH_LF);
        c = 8'h55;
        tif.char_in    = c;
        tif.char_valid = 1'b1;
        repeat (10) tick();
        tif.cls = 1'b1;
        tick();
        tif.cls = 1'b0;
        n = 0;
        while (!tif.char_ready && n < 6000) begin
            tick();
            n++;
        end
        `CHK("cont_ready", tif.char_ready, 1'b1)
        tick();
        tif.char_valid = 1'b0;
        model_clear();
        model_char(c);
        drain();
        `CHK("cont_writes", wa.size(), 2401)
        `CHK("cont_first_addr", wa[0], 0)
        `CHK("cont_first_data", wd[0], row1_char)
        `CHK("cont_last_addr", wa[wa.size()-1], 0)
        `CHK("cont_last_data", wd[wd.size()-1], 8'h55)
        check_cursor("cont_cursor");
        check_screen("cont_screen");

        // Reset in the middle of a scroll
        repeat (ROWS - 1) send(CH_LF);
        send(CH_LF);
        repeat (100) tick();
        reset = 1'b0;
        #1;
        check_reset_values();
        tick();
        reset = 1'b1;
        drain();
        model_clear();
        check_screen("midrst_screen");
        check_cursor("midrst_cursor");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
